pll_supervisor_cegen: RTL and testbench
=======================================

Name: pll_supervisor_cegen

Overview:
- Supervises a clocking primitive on the 50 MHz reference clock.
- Drives the primitive's reset and qualifies its lock signal, with timeout, retry and fault handling.
- Generates a sequenced system reset plus NUM_CE fractional clock enables, one phase accumulator (NCO) per channel.
- Replaces fixed multiply/divide ratios with run-time programmable enable rates; sits between the clocking wrapper and core logic.

Parameters:
- NUM_CE, 2, number of clock-enable channels (1..8).
- ACC_W, 24, phase accumulator width per channel.
- RST_HOLD, 16, cycles pll_rst is held asserted per attempt (>=1).
- LOCK_TIMEOUT, 65535, max cycles waiting for lock per attempt.
- STABLE_CYCLES, 1024, consecutive locked cycles required before release.
- MAX_RETRIES, 3, failed lock attempts allowed before fault (>=1).

Ports:
- refclk  in  1  reference clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- pll_locked  in  1  lock from clocking primitive; asynchronous, 2-flop synchronised internally.
- pll_rst  out  1  reset to clocking primitive.
- ce_inc  in  NUM_CE*ACC_W  per-channel phase increment; channel i at bits [i*ACC_W +: ACC_W]; sampled every cycle.
- ce_out  out  NUM_CE  registered one-cycle enable pulses.
- sys_rst  out  1  system reset; high except in RUN.
- ready  out  1  high in RUN.
- fault  out  1  sticky: retries exhausted.
- retry_cnt  out  clog2(MAX_RETRIES+1)  failed attempts in the current supervision cycle.

Behaviour:
- Reset values (rst=1): state=HOLD, pll_rst=1, sys_rst=1, ready=0, fault=0, ce_out=0, retry_cnt=0, all accumulators=0, all counters=0.
- lk = pll_locked after 2-flop synchroniser (2-cycle latency); all decisions use lk.
- HOLD:
  - pll_rst=1 for exactly RST_HOLD cycles, then go to WAIT.
  - Counter clears on entry.
- WAIT:
  - pll_rst=0; timeout counter runs.
  - lk=1 -> STABLE.
  - Counter reaches LOCK_TIMEOUT without lk -> retry_cnt+1.
    - If the new value equals MAX_RETRIES -> FAULT.
    - Otherwise -> HOLD.
- STABLE:
  - Counts consecutive lk=1 cycles.
  - lk=0 -> counter clears; return to WAIT with a fresh timeout (not a retry).
  - Count reaches STABLE_CYCLES -> RUN.
- RUN:
  - sys_rst=0 and ready=1, registered; both change the cycle after entry.
  - lk=0 for one cycle -> HOLD next cycle; sys_rst=1 and ready=0 immediately from that edge.
  - Lock loss in RUN does not increment retry_cnt.
  - retry_cnt clears on entry to RUN.
- FAULT:
  - pll_rst=1, sys_rst=1, fault=1.
  - Only rst exits.
- NCO, per channel i:
  - In RUN: {carry,acc_i} = acc_i + ce_inc_i (ACC_W+1 bits); ce_out[i] <= carry.
  - Outside RUN: acc_i <= 0, ce_out[i] <= 0.
  - Average ce rate = f_refclk * inc / 2^ACC_W.
  - inc=0 -> never pulses.
  - inc=2^(ACC_W-1) -> pulses every 2nd cycle.
  - inc=2^ACC_W-1 -> pulses on all cycles but one per 2^ACC_W.
  - Accumulator wraps modulo 2^ACC_W; ce_inc may change at any cycle and takes effect on the next add.
- Simultaneous events: rst dominates everything; a timeout and lk rising in the same WAIT cycle -> lk wins (go to STABLE).
- rst mid-operation: all state returns to reset values the following cycle, including sticky fault.

Optional Feature:
- Macro: LOCK_LOSS_COUNT_EN.
- Defined:
  - Adds output lock_loss_cnt, 8 bits.
  - Increments on each RUN->HOLD transition and saturates at 255.
  - Clears only on rst.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Nominal lock: RST_HOLD=16, STABLE_CYCLES=1024, lk rises 100 cycles after pll_rst falls -> sys_rst falls exactly 2+1024+1 cycles after pll_locked rises; ready=1, retry_cnt=0.
- Timeout/retry/fault: LOCK_TIMEOUT=200, MAX_RETRIES=3, pll_locked held 0 -> three HOLD/WAIT rounds with retry_cnt 1, 2, then fault=1; fault and pll_rst stay high until rst.
- Glitch in STABLE: drop pll_locked for 1 cycle at stable count 500 -> stable counter restarts; release occurs 1024 lk cycles after relock; retry_cnt unchanged.
- Lock loss in RUN: pulse pll_locked low for 1 cycle -> sys_rst=1 within 3 cycles, pll_rst high for 16 cycles, relock sequence repeats; lock_loss_cnt=1 if LOCK_LOSS_COUNT_EN.
- NCO rates: ACC_W=24, inc0=0x800000, inc1=0x555555, run for 3000 cycles -> ce_out[0] every 2nd cycle (1500 pulses); ce_out[1] 1000±1 pulses; inc=0 -> zero pulses.
- Reset mid-run: assert rst for 1 cycle in RUN with accumulators nonzero -> all outputs return to reset values next cycle; full lock sequence restarts.

Source files
------------

// File: rtl/pll_supervisor_cegen.sv
// PLL supervisor: lock qualification, retry/fault handling, sequenced reset and NCO clock enables.
// Optional LOCK_LOSS_COUNT_EN adds a saturating lock_loss_cnt output.
module pll_supervisor_cegen #(
    parameter int NUM_CE        = 2,
    parameter int ACC_W         = 24,
    parameter int RST_HOLD      = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                               refclk,
    input  logic                               rst,
    input  logic                               pll_locked,
    output logic                               pll_rst,
    input  logic [NUM_CE*ACC_W-1:0]            ce_inc,
    output logic [NUM_CE-1:0]                  ce_out,
    output logic                               sys_rst,
    output logic                               ready,
    output logic                               fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
`ifdef LOCK_LOSS_COUNT_EN
    ,
    output logic [7:0]                         lock_loss_cnt
`endif
);

    localparam int RTW    = $clog2(MAX_RETRIES + 1);
    localparam int CMAX_A = (RST_HOLD > LOCK_TIMEOUT) ? RST_HOLD : LOCK_TIMEOUT;
    localparam int CMAX   = (CMAX_A > STABLE_CYCLES) ? CMAX_A : STABLE_CYCLES;
    localparam int CNT_W  = $clog2(CMAX + 1);

    localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] TO_END    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_END   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RTW-1:0]   RETRY_MAX = RTW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [RTW-1:0]     retry_nxt;
    logic [RTW-1:0]     retry_inc;
    logic [1:0]         sync;
    logic               lk;
    logic               run;
    logic               run_keep;

    assign lk        = sync[1];
    assign retry_inc = retry_cnt + RTW'(1);
    assign run_keep  = run && (state_nxt == S_RUN);

    // sys_rst/ready follow "staying in RUN", so they release one cycle
    // after entry but reassert on the very edge that leaves RUN.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= S_HOLD;
            cnt       <= '0;
            retry_cnt <= '0;
            sync      <= '0;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry_cnt <= retry_nxt;
            sync      <= {sync[0], pll_locked};
            sys_rst   <= ~run_keep;
            ready     <= run_keep;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        retry_nxt = retry_cnt;
        unique case (state)
            S_HOLD: begin
                if (cnt == HOLD_END) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = '0;
                end
            end
            S_WAIT: begin
                // The lk cycle seen here is the first stable cycle.
                if (lk) begin
                    state_nxt = (STABLE_CYCLES > 1) ? S_STABLE : S_RUN;
                    cnt_nxt   = CNT_W'(1);
                end else if (cnt == TO_END) begin
                    retry_nxt = retry_inc;
                    state_nxt = (retry_inc == RETRY_MAX) ? S_FAULT : S_HOLD;
                    cnt_nxt   = '0;
                end
            end
            S_STABLE: begin
                if (!lk) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = '0;
                end else if (cnt >= STB_END) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                cnt_nxt = '0;
                if (!lk) begin
                    state_nxt = S_HOLD;
                end
            end
            S_FAULT: begin
                cnt_nxt = '0;
            end
            default: begin
                state_nxt = S_HOLD;
                cnt_nxt   = '0;
            end
        endcase
        if (state_nxt == S_RUN && state != S_RUN) begin
            retry_nxt = '0;
        end
    end

    always_comb begin
        pll_rst = 1'b0;
        fault   = 1'b0;
        run     = 1'b0;
        unique case (state)
            S_HOLD: begin
                pll_rst = 1'b1;
            end
            S_FAULT: begin
                pll_rst = 1'b1;
                fault   = 1'b1;
            end
            S_RUN: begin
                run = 1'b1;
            end
            default: begin
                run = 1'b0;
            end
        endcase
    end

    logic [ACC_W-1:0] acc [NUM_CE];
    logic [ACC_W:0]   sum [NUM_CE];

    always_comb begin
        for (int i = 0; i < NUM_CE; i++) begin
            sum[i] = {1'b0, acc[i]} + {1'b0, ce_inc[i*ACC_W +: ACC_W]};
        end
    end

    // Accumulator carry-out is the enable; idle channels hold at zero phase.
    always_ff @(posedge refclk) begin
        for (int i = 0; i < NUM_CE; i++) begin
            if (rst || !run) begin
                acc[i]    <= '0;
                ce_out[i] <= 1'b0;
            end else begin
                acc[i]    <= sum[i][ACC_W-1:0];
                ce_out[i] <= sum[i][ACC_W];
            end
        end
    end

`ifdef LOCK_LOSS_COUNT_EN
    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_loss_cnt <= '0;
        end else if (run && state_nxt == S_HOLD && lock_loss_cnt != 8'hFF) begin
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pll_supervisor_cegen.sv
// Scoreboard bench for pll_supervisor_cegen: timed expectations queued by
// the stimulus, popped and compared by an independent monitor.
module tb_pll_supervisor_cegen;

    localparam int NUM_CE = 2;
    localparam int ACC_W  = 24;

    logic                      refclk = 1'b0;
    logic                      rst = 1'b1;
    logic                      pll_locked = 1'b0;
    logic [NUM_CE*ACC_W-1:0]   ce_inc = '0;
    logic                      pll_rst;
    logic [NUM_CE-1:0]         ce_out;
    logic                      sys_rst;
    logic                      ready;
    logic                      fault;
    logic [1:0]                retry_cnt;
`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0]                lock_loss_cnt;
`endif

    pll_supervisor_cegen #(
        .NUM_CE(NUM_CE),
        .ACC_W(ACC_W),
        .RST_HOLD(16),
        .LOCK_TIMEOUT(200),
        .STABLE_CYCLES(1024),
        .MAX_RETRIES(3)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .pll_locked(pll_locked),
        .pll_rst(pll_rst),
        .ce_inc(ce_inc),
        .ce_out(ce_out),
        .sys_rst(sys_rst),
        .ready(ready),
        .fault(fault),
        .retry_cnt(retry_cnt)
`ifdef LOCK_LOSS_COUNT_EN
        ,
        .lock_loss_cnt(lock_loss_cnt)
`endif
    );

    always #10 refclk = ~refclk;

    int cyc = 0;
    always @(posedge refclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cyc;
        int kind;
        int pr, sr, rd, fl, rt, ce, llc;
        int lo0, hi0, lo1, hi1;
    } exp_t;

    exp_t sb[$];

    task automatic push_full(int c, int pr, int sr, int rd, int fl,
                             int rt, int ce, int llc);
        exp_t e;
        e.cyc = c; e.kind = 0;
        e.pr = pr; e.sr = sr; e.rd = rd; e.fl = fl;
        e.rt = rt; e.ce = ce; e.llc = llc;
        e.lo0 = 0; e.hi0 = 0; e.lo1 = 0; e.hi1 = 0;
        sb.push_back(e);
    endtask

    task automatic push_o(int c, int pr, int sr, int rd, int fl, int rt);
        push_full(c, pr, sr, rd, fl, rt, -1, -1);
    endtask

    task automatic push_win(int c, int kind, int lo0, int hi0,
                            int lo1, int hi1);
        exp_t e;
        e.cyc = c; e.kind = kind;
        e.pr = -1; e.sr = -1; e.rd = -1; e.fl = -1;
        e.rt = -1; e.ce = -1; e.llc = -1;
        e.lo0 = lo0; e.hi0 = hi0; e.lo1 = lo1; e.hi1 = hi1;
        sb.push_back(e);
    endtask

    task automatic chk(string nm, logic [31:0] act, int exp);
        if (exp >= 0) begin
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d: got %0d expected %0d",
                         nm, cyc, act, exp);
            end
        end
    endtask

    task automatic chk_rng(string nm, int act, int lo, int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d..%0d",
                     nm, cyc, act, lo, hi);
        end
    endtask

    // Monitor: owns the pulse counters and all comparisons.
    initial begin
        exp_t e;
        int c0, c1;
        bit win;
        c0 = 0; c1 = 0; win = 0;
        forever begin
            @(negedge refclk);
            if (win) begin
                c0 += int'(ce_out[0]);
                c1 += int'(ce_out[1]);
            end
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL record_missed: cycle %0d scheduled %0d",
                             cyc, e.cyc);
                end else if (e.kind == 0) begin
                    chk("pll_rst", 32'(pll_rst), e.pr);
                    chk("sys_rst", 32'(sys_rst), e.sr);
                    chk("ready", 32'(ready), e.rd);
                    chk("fault", 32'(fault), e.fl);
                    chk("retry_cnt", 32'(retry_cnt), e.rt);
                    chk("ce_out", 32'(ce_out), e.ce);
`ifdef LOCK_LOSS_COUNT_EN
                    chk("lock_loss_cnt", 32'(lock_loss_cnt), e.llc);
`endif
                end else if (e.kind == 1) begin
                    win = 1;
                    c0 = int'(ce_out[0]);
                    c1 = int'(ce_out[1]);
                end else begin
                    chk_rng("ce0_count", c0, e.lo0, e.hi0);
                    chk_rng("ce1_count", c1, e.lo1, e.hi1);
                    win = 0;
                end
            end
        end
    end

    task automatic wait_cyc(int c);
        while (cyc < c) @(negedge refclk);
    endtask

    // One-cycle synchronous reset; returns the cycle of the reset edge.
    task automatic do_reset(output int r);
        int t;
        t = cyc + 1;
        push_full(t, 1, 1, 0, 0, 0, 0, 0);
        rst = 1'b1;
        pll_locked = 1'b0;
        wait_cyc(t);
        rst = 1'b0;
        r = cyc;
    endtask

    initial begin
        #(40000 * 20);
        $display("FAIL watchdog: cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r, l;
        @(negedge refclk);
        ce_inc = {24'h555555, 24'h800000};

        // Nominal lock followed by NCO rate windows
        do_reset(r);
        push_o(r + 15, 1, 1, 0, 0, 0);
        push_o(r + 16, 0, 1, 0, 0, 0);
        push_o(r + 1142, 0, 1, 0, 0, 0);
        push_o(r + 1143, 0, 0, 1, 0, 0);
        push_win(r + 1143, 1, 0, 0, 0, 0);
        push_win(r + 4142, 2, 1500, 1500, 999, 1001);
        push_win(r + 4151, 1, 0, 0, 0, 0);
        push_win(r + 4350, 2, 0, 0, 200, 200);
        wait_cyc(r + 116);
        pll_locked = 1'b1;
        wait_cyc(r + 4150);
        ce_inc = {24'hFFFFFF, 24'h000000};
        wait_cyc(r + 4360);

        // Reset mid-run, relock, then a one-cycle lock loss in RUN
        do_reset(r);
        l = r + 1100;
        push_o(r + 15, 1, 1, 0, 0, 0);
        push_o(r + 16, 0, 1, 0, 0, 0);
        push_o(r + 1046, 0, 1, 0, 0, 0);
        push_o(r + 1047, 0, 0, 1, 0, 0);
        push_o(l + 2, 0, 0, 1, 0, 0);
        push_o(l + 3, 1, 1, 0, 0, 0);
        push_o(l + 18, 1, 1, 0, 0, 0);
        push_o(l + 19, 0, 1, 0, 0, 0);
        push_o(l + 1043, 0, 1, 0, 0, 0);
        push_full(l + 1044, 0, 0, 1, 0, 0, -1, 1);
        wait_cyc(r + 20);
        pll_locked = 1'b1;
        wait_cyc(l);
        pll_locked = 1'b0;
        wait_cyc(l + 1);
        pll_locked = 1'b1;
        wait_cyc(l + 1060);

        // Glitch during STABLE restarts the stable count
        do_reset(r);
        push_o(r + 524, 0, 1, 0, 0, 0);
        push_o(r + 1047, 0, 1, 0, 0, 0);
        push_o(r + 1548, 0, 1, 0, 0, 0);
        push_o(r + 1549, 0, 0, 1, 0, 0);
        wait_cyc(r + 20);
        pll_locked = 1'b1;
        wait_cyc(r + 521);
        pll_locked = 1'b0;
        wait_cyc(r + 522);
        pll_locked = 1'b1;
        wait_cyc(r + 1560);

        // Timeouts exhaust retries into FAULT
        do_reset(r);
        push_o(r + 15, 1, 1, 0, 0, 0);
        push_o(r + 16, 0, 1, 0, 0, 0);
        push_o(r + 215, 0, 1, 0, 0, 0);
        push_o(r + 216, 1, 1, 0, 0, 1);
        push_o(r + 231, 1, 1, 0, 0, 1);
        push_o(r + 232, 0, 1, 0, 0, 1);
        push_o(r + 431, 0, 1, 0, 0, 1);
        push_o(r + 432, 1, 1, 0, 0, 2);
        push_o(r + 647, 0, 1, 0, 0, 2);
        push_o(r + 648, 1, 1, 0, 1, 3);
        push_o(r + 900, 1, 1, 0, 1, 3);
        wait_cyc(r + 700);
        pll_locked = 1'b1;
        wait_cyc(r + 910);

        // Only rst clears the fault
        do_reset(r);
        push_o(r + 15, 1, 1, 0, 0, 0);
        push_o(r + 16, 0, 1, 0, 0, 0);
        wait_cyc(r + 25);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0",
                     sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
